cpu_regfile_sb: RTL and testbench

Parametrised general-purpose register file with an integrated write-pending scoreboard for the pipelined CPU. It provides N combinational read ports with writeback bypass and one writeback port. A busy bit per register is set at issue and cleared at writeback, so decode can detect RAW hazards. A flush clears all pending entries on pipeline squash.

---
 rtl/cpu_rf_pkg.sv | 16 +
 rtl/cpu_rf_scoreboard.sv | 69 ++++++
 rtl/cpu_regfile_sb.sv | 89 ++++++++
 tb/tb_cpu_regfile_sb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared constants, types and helpers for the CPU register file and its scoreboard.
package cpu_rf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_AW     = $clog2(DEF_NREGS);

  // Register address for the default configuration
  typedef logic [DEF_AW-1:0] gpr_addr_t;

  // LSB of port k's slice inside a flattened per-port vector of w-bit fields
  function automatic int port_slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/cpu_rf_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set at issue, cleared at
// writeback or flush, plus per-read-port hazard lookup.
module cpu_rf_scoreboard
  import cpu_rf_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = $clog2(NREGS),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic                flush,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic [NREAD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [AW-1:0]    rd_a [NREAD];

  // Busy next-state: flush beats issue, issue beats writeback, else hold
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush)
        busy_nxt[r] = 1'b0;
      else if (iss_en && (iss_addr == AW'(r)))
        busy_nxt[r] = 1'b1;
      else if (wb_en && (wb_addr == AW'(r)))
        busy_nxt[r] = 1'b0;
    end
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  // Busy bit register array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= busy_nxt;
  end

  // Split the flattened read address bus into per-port addresses
  always_comb begin
    for (int k = 0; k < NREAD; k++)
      rd_a[k] = rd_addr[port_slice_lsb(k, AW) +: AW];
  end

  // Per-port hazard: a same-cycle writeback hides the hazard because the bypass
  // already delivers the new value; a same-cycle issue only matters next cycle
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_busy[k] = busy_q[rd_a[k]] && !(wb_en && (wb_addr == rd_a[k]));
      if ((ZERO_REG != 0) && (rd_a[k] == '0))
        rd_busy[k] = 1'b0;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/cpu_regfile_sb.sv
// General-purpose register file with writeback bypass on every read port and an
// attached write-pending scoreboard for RAW hazard detection.
module cpu_regfile_sb
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = $clog2(NREGS),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     i_rd_addr,
  output logic [NREAD*DATA_W-1:0] o_rd_data,
  output logic [NREAD-1:0]        o_rd_busy,
  input  logic                    i_iss_en,
  input  logic [AW-1:0]           i_iss_addr,
  input  logic                    i_wb_en,
  input  logic [AW-1:0]           i_wb_addr,
  input  logic [DATA_W-1:0]       i_wb_data,
  input  logic                    i_flush,
  output logic [NREGS-1:0]        o_busy_vec,
  output logic [NREGS*DATA_W-1:0] o_gpr_data
);

  logic [DATA_W-1:0] gpr_q [NREGS];
  logic [AW-1:0]     rd_a  [NREAD];
  logic              wb_ok;

  // A writeback to the hardwired zero register is discarded for both the
  // array and the bypass path
  assign wb_ok = i_wb_en && !((ZERO_REG != 0) && (i_wb_addr == '0));

  // GPR data array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++)
        gpr_q[r] <= '0;
    end else if (wb_ok) begin
      gpr_q[i_wb_addr] <= i_wb_data;
    end
  end

  // Split the flattened read address bus into per-port addresses
  always_comb begin
    for (int k = 0; k < NREAD; k++)
      rd_a[k] = i_rd_addr[port_slice_lsb(k, AW) +: AW];
  end

  // Read ports: zero register, then writeback bypass, then array contents
  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      if ((ZERO_REG != 0) && (rd_a[k] == '0))
        o_rd_data[port_slice_lsb(k, DATA_W) +: DATA_W] = '0;
      else if (wb_ok && (i_wb_addr == rd_a[k]))
        o_rd_data[port_slice_lsb(k, DATA_W) +: DATA_W] = i_wb_data;
      else
        o_rd_data[port_slice_lsb(k, DATA_W) +: DATA_W] = gpr_q[rd_a[k]];
    end
  end

  // Flattened view of every register for debug
  always_comb begin
    o_gpr_data = '0;
    for (int r = 0; r < NREGS; r++)
      o_gpr_data[port_slice_lsb(r, DATA_W) +: DATA_W] = gpr_q[r];
  end

  cpu_rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (i_iss_en),
    .iss_addr (i_iss_addr),
    .wb_en    (i_wb_en),
    .wb_addr  (i_wb_addr),
    .flush    (i_flush),
    .rd_addr  (i_rd_addr),
    .busy_vec (o_busy_vec),
    .rd_busy  (o_rd_busy)
  );

endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Bench for cpu_regfile_sb: directed cases on default and zero-register
// instances, then a random mix on a wide instance against a reference model.
module tb_cpu_regfile_sb;
  import cpu_rf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // default instance
  logic [5:0]   a_rd_addr;
  logic [31:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_iss_en, a_wb_en, a_flush;
  gpr_addr_t    a_iss_addr, a_wb_addr;
  logic [15:0]  a_wb_data;
  logic [7:0]   a_busy_vec;
  logic [127:0] a_gpr;

  // zero-register instance
  logic [5:0]   b_rd_addr;
  logic [31:0]  b_rd_data;
  logic [1:0]   b_rd_busy;
  logic         b_iss_en, b_wb_en, b_flush;
  gpr_addr_t    b_iss_addr, b_wb_addr;
  logic [15:0]  b_wb_data;
  logic [7:0]   b_busy_vec;
  logic [127:0] b_gpr;

  // wide instance
  logic [11:0]  c_rd_addr;
  logic [95:0]  c_rd_data;
  logic [2:0]   c_rd_busy;
  logic         c_iss_en, c_wb_en, c_flush;
  logic [3:0]   c_iss_addr, c_wb_addr;
  logic [31:0]  c_wb_data;
  logic [15:0]  c_busy_vec;
  logic [511:0] c_gpr;

  cpu_regfile_sb u_dut_a (
    .clk(clk), .reset(reset), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
    .o_rd_busy(a_rd_busy), .i_iss_en(a_iss_en), .i_iss_addr(a_iss_addr),
    .i_wb_en(a_wb_en), .i_wb_addr(a_wb_addr), .i_wb_data(a_wb_data),
    .i_flush(a_flush), .o_busy_vec(a_busy_vec), .o_gpr_data(a_gpr)
  );

  cpu_regfile_sb #(.ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset(reset), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .o_rd_busy(b_rd_busy), .i_iss_en(b_iss_en), .i_iss_addr(b_iss_addr),
    .i_wb_en(b_wb_en), .i_wb_addr(b_wb_addr), .i_wb_data(b_wb_data),
    .i_flush(b_flush), .o_busy_vec(b_busy_vec), .o_gpr_data(b_gpr)
  );

  cpu_regfile_sb #(.DATA_W(32), .NREGS(16), .NREAD(3)) u_dut_c (
    .clk(clk), .reset(reset), .i_rd_addr(c_rd_addr), .o_rd_data(c_rd_data),
    .o_rd_busy(c_rd_busy), .i_iss_en(c_iss_en), .i_iss_addr(c_iss_addr),
    .i_wb_en(c_wb_en), .i_wb_addr(c_wb_addr), .i_wb_data(c_wb_data),
    .i_flush(c_flush), .o_busy_vec(c_busy_vec), .o_gpr_data(c_gpr)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    a_iss_en = 0; a_wb_en = 0; a_flush = 0; a_iss_addr = '0; a_wb_addr = '0; a_wb_data = '0;
    b_iss_en = 0; b_wb_en = 0; b_flush = 0; b_iss_addr = '0; b_wb_addr = '0; b_wb_data = '0;
    c_iss_en = 0; c_wb_en = 0; c_flush = 0; c_iss_addr = '0; c_wb_addr = '0; c_wb_data = '0;
  endtask

  // reference model state for the wide instance
  logic [31:0] m_gpr [16];
  logic [15:0] m_busy;

  initial begin
    logic [3:0]  ra;
    logic [31:0] exp_d;
    logic        exp_b;

    reset = 1'b0;
    idle_all();
    a_rd_addr = '0; b_rd_addr = '0; c_rd_addr = '0;
    for (int r = 0; r < 16; r++) m_gpr[r] = '0;
    m_busy = '0;

    #2;
    chk("rst_a_rd_data", a_rd_data, 0);
    chk("rst_a_rd_busy", a_rd_busy, 0);
    chk("rst_a_busy_vec", a_busy_vec, 0);
    chk("rst_a_gpr", a_gpr, 0);
    chk("rst_b_gpr", b_gpr, 0);
    chk("rst_c_gpr", c_gpr, 0);
    chk("rst_c_busy_vec", c_busy_vec, 0);

    @(negedge clk); reset = 1'b1;

    // write then read back
    @(negedge clk); a_wb_en = 1; a_wb_addr = 3; a_wb_data = 16'hBEEF;
    @(negedge clk); idle_all(); a_rd_addr = {3'd0, 3'd3}; #1;
    chk("wr_rd0", a_rd_data[15:0], 16'hBEEF);
    chk("wr_gpr3", a_gpr[3*16 +: 16], 16'hBEEF);

    // same-cycle bypass on port 1
    @(negedge clk); a_wb_en = 1; a_wb_addr = 5; a_wb_data = 16'h1234; a_rd_addr = {3'd5, 3'd0}; #1;
    chk("byp_rd1", a_rd_data[31:16], 16'h1234);
    chk("byp_gpr5_old", a_gpr[5*16 +: 16], 0);
    @(negedge clk); idle_all(); #1;
    chk("byp_gpr5_new", a_gpr[5*16 +: 16], 16'h1234);

    // scoreboard issue / writeback of R2
    @(negedge clk); a_iss_en = 1; a_iss_addr = 2; a_rd_addr = {3'd0, 3'd2}; #1;
    chk("iss_same_cyc_busy", a_rd_busy[0], 0);
    @(negedge clk); idle_all(); #1;
    chk("iss_busy_vec2", a_busy_vec[2], 1);
    chk("iss_rd_busy0", a_rd_busy[0], 1);
    @(negedge clk); #1;
    chk("iss_hold", a_busy_vec[2], 1);
    @(negedge clk); a_wb_en = 1; a_wb_addr = 2; a_wb_data = 16'h00AA; #1;
    chk("wb_mask_busy", a_rd_busy[0], 0);
    chk("wb_byp_data", a_rd_data[15:0], 16'h00AA);
    chk("wb_reg_still_busy", a_busy_vec[2], 1);
    @(negedge clk); idle_all(); #1;
    chk("wb_busy_clr", a_busy_vec[2], 0);
    chk("wb_gpr2", a_gpr[2*16 +: 16], 16'h00AA);

    // issue and writeback of R6 in one cycle
    @(negedge clk); a_iss_en = 1; a_iss_addr = 6; a_wb_en = 1; a_wb_addr = 6; a_wb_data = 16'h6666;
    @(negedge clk); idle_all(); #1;
    chk("isswb_gpr6", a_gpr[6*16 +: 16], 16'h6666);
    chk("isswb_busy6", a_busy_vec[6], 1);

    // flush with concurrent issue
    @(negedge clk); a_iss_en = 1; a_iss_addr = 4;
    @(negedge clk); idle_all(); a_flush = 1; a_iss_en = 1; a_iss_addr = 1; #1;
    chk("pre_flush_vec", a_busy_vec, 8'h50);
    @(negedge clk); idle_all(); #1;
    chk("flush_vec", a_busy_vec, 0);

    // hardwired zero register
    @(negedge clk); b_iss_en = 1; b_iss_addr = 0; b_wb_en = 1; b_wb_addr = 0; b_wb_data = 16'hFFFF;
    b_rd_addr = {3'd0, 3'd0}; #1;
    chk("zr_rd_byp", b_rd_data, 0);
    chk("zr_rd_busy", b_rd_busy, 0);
    @(negedge clk); idle_all(); #1;
    chk("zr_busy_vec", b_busy_vec, 0);
    chk("zr_gpr0", b_gpr[15:0], 0);
    chk("zr_rd0", b_rd_data[15:0], 0);
    @(negedge clk); b_wb_en = 1; b_wb_addr = 1; b_wb_data = 16'h0101; b_rd_addr = {3'd1, 3'd0}; #1;
    chk("zr_r1_byp", b_rd_data[31:16], 16'h0101);
    @(negedge clk); idle_all(); #1;
    chk("zr_r1_gpr", b_gpr[16 +: 16], 16'h0101);

    // async reset without a clock edge
    @(negedge clk); a_iss_en = 1; a_iss_addr = 7; a_wb_en = 1; a_wb_addr = 7; a_wb_data = 16'h5555;
    @(negedge clk); idle_all(); a_rd_addr = {3'd7, 3'd7}; #1;
    chk("pre_arst_gpr7", a_gpr[7*16 +: 16], 16'h5555);
    chk("pre_arst_busy7", a_busy_vec[7], 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_gpr", a_gpr, 0);
    chk("arst_busy_vec", a_busy_vec, 0);
    chk("arst_rd_data", a_rd_data, 0);
    chk("arst_rd_busy", a_rd_busy, 0);
    #1 reset = 1'b1;

    // random traffic on the wide instance
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      c_iss_en   = ($urandom_range(0, 1) == 1);
      c_iss_addr = 4'($urandom_range(0, 15));
      c_wb_en    = ($urandom_range(0, 1) == 1);
      c_wb_addr  = 4'($urandom_range(0, 15));
      c_wb_data  = $urandom;
      c_flush    = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) c_rd_addr[k*4 +: 4] = c_wb_addr;
        else c_rd_addr[k*4 +: 4] = 4'($urandom_range(0, 15));
      end
      #1;
      chk("rnd_busy_vec", c_busy_vec, m_busy);
      for (int k = 0; k < 3; k++) begin
        ra    = c_rd_addr[k*4 +: 4];
        exp_d = (c_wb_en && c_wb_addr == ra) ? c_wb_data : m_gpr[ra];
        exp_b = m_busy[ra] && !(c_wb_en && c_wb_addr == ra);
        chk("rnd_rd_data", c_rd_data[k*32 +: 32], exp_d);
        chk("rnd_rd_busy", c_rd_busy[k], exp_b);
      end
      // state after the coming edge: later rules override earlier ones
      if (c_wb_en) begin
        m_gpr[c_wb_addr]  = c_wb_data;
        m_busy[c_wb_addr] = 1'b0;
      end
      if (c_iss_en) m_busy[c_iss_addr] = 1'b1;
      if (c_flush)  m_busy = '0;
    end
    @(negedge clk); idle_all(); #1;
    chk("rnd_final_busy", c_busy_vec, m_busy);
    for (int r = 0; r < 16; r++)
      chk("rnd_final_gpr", c_gpr[r*32 +: 32], m_gpr[r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
